// File: rtl/ccff_loader_if.sv
// ccff_loader_if: word-load handshake, chain-side serial signals and status for ccff_loader.
interface ccff_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, cfg_data, cfg_valid, ccff_tail,
    input  cfg_ready, ccff_head, ccff_shift_en, busy, done, error
  );

  modport slave (
    input  start, cfg_data, cfg_valid, ccff_tail,
    output cfg_ready, ccff_head, ccff_shift_en, busy, done, error
  );
endinterface

// File: rtl/ccff_loader.sv
// ccff_loader: serialises parallel config words LSB-first into a CHAIN_LEN-flop ccff chain.
// Build option CCFF_LOADER_TAIL_CHECK_EN adds a one-cycle tail check of the first loaded bit.
module ccff_loader #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned WORD_W    = 8
) (
  input logic          prog_clk,
  input logic          pReset,
  ccff_loader_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WC_W  = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  LAST_WBIT = WC_W'(WORD_W - 1);

`ifdef CCFF_LOADER_TAIL_CHECK_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_SHIFT = 3'd2, S_CHECK = 3'd3, S_DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_SHIFT = 3'd2, S_DONE = 3'd4
  } state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WC_W-1:0]   r_word_cnt;
  logic              w_start_acc;
  logic              w_xfer;
  logic              w_last_bit;
  logic              r_cfg_ready;
  logic              r_head;
  logic              r_shift_en;
  logic              r_busy;
  logic              r_done;

  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  // Next state; a word ends early when the chain is full, which drops the unused upper bits.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_start_acc = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_LOAD;
          w_start_acc = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (bus.cfg_valid) begin
          w_xfer      = 1'b1;
          w_shift_nxt = bus.cfg_data;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_SHIFT: begin
        w_shift_nxt = r_shift >> 1;
        if (w_last_bit) begin
`ifdef CCFF_LOADER_TAIL_CHECK_EN
          w_state_nxt = S_CHECK;
`else
          w_state_nxt = S_DONE;
`endif
        end else if (r_word_cnt == LAST_WBIT) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
`ifdef CCFF_LOADER_TAIL_CHECK_EN
      S_CHECK: w_state_nxt = S_DONE;
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      r_shift <= w_shift_nxt;
      if (w_start_acc) begin
        r_bit_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1'b1);
      end
      if (w_xfer) begin
        r_word_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_word_cnt <= r_word_cnt + WC_W'(1'b1);
      end
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_cfg_ready <= 1'b0;
      r_head      <= 1'b0;
      r_shift_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cfg_ready <= (w_state_nxt == S_LOAD);
      r_shift_en  <= (w_state_nxt == S_SHIFT);
      r_head      <= (w_state_nxt == S_SHIFT) ? w_shift_nxt[0] : 1'b0;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

`ifdef CCFF_LOADER_TAIL_CHECK_EN
  logic r_first_bit;
  logic r_error;

  // After CHAIN_LEN shifts the first bit sent must be back at the tail.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_first_bit <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if ((r_state == S_SHIFT) && (r_bit_cnt == '0)) begin
        r_first_bit <= r_shift[0];
      end
      if (w_start_acc) begin
        r_error <= 1'b0;
      end else if ((r_state == S_CHECK) && (bus.ccff_tail != r_first_bit)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.error = r_error;
`else
  logic w_unused_tail;
  assign w_unused_tail = bus.ccff_tail;
  assign bus.error     = 1'b0;
`endif

  assign bus.cfg_ready     = r_cfg_ready;
  assign bus.ccff_head     = r_head;
  assign bus.ccff_shift_en = r_shift_en;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: random and directed loads checked against a word-concatenation model of the chain stream.
module tb_ccff_loader;
  localparam int LEN_A = 12;
  localparam int LEN_B = 1;
  localparam int W     = 8;
`ifdef CCFF_LOADER_TAIL_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  int   n_total  = 0;
  int   n_bad    = 0;
  int   cyc      = 0;

  ccff_loader_if #(.WORD_W(W)) ifa ();
  ccff_loader_if #(.WORD_W(W)) ifb ();

  ccff_loader #(.CHAIN_LEN(LEN_A), .WORD_W(W)) dut_a (.prog_clk(prog_clk), .pReset(pReset), .bus(ifa));
  ccff_loader #(.CHAIN_LEN(LEN_B), .WORD_W(W)) dut_b (.prog_clk(prog_clk), .pReset(pReset), .bus(ifb));

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Downstream chain models; the tail of chain A can be overridden to inject a fault.
  logic [LEN_A-1:0] chain_a = '0;
  logic             chain_b = 1'b0;
  logic             force_tail_en  = 1'b0;
  logic             force_tail_val = 1'b0;
  always @(posedge prog_clk) begin
    if (ifa.ccff_shift_en) chain_a <= {chain_a[LEN_A-2:0], ifa.ccff_head};
    if (ifb.ccff_shift_en) chain_b <= ifb.ccff_head;
  end
  assign ifa.ccff_tail = force_tail_en ? force_tail_val : chain_a[LEN_A-1];
  assign ifb.ccff_tail = chain_b;

  logic       got_a[$];
  logic [7:0] acc_a[$];
  int done_a = 0, done_cyc_a = 0, head_viol = 0;
  int en_b = 0, acc_b = 0, done_b = 0, done_cyc_b = 0;
  logic head_b = 1'b0;
  always @(negedge prog_clk) begin
    if (ifa.ccff_shift_en) got_a.push_back(ifa.ccff_head);
    else if (ifa.ccff_head) head_viol++;
    if (ifa.cfg_valid && ifa.cfg_ready) acc_a.push_back(ifa.cfg_data);
    if (ifa.done) begin done_a++; done_cyc_a = cyc; end
    if (ifb.ccff_shift_en) begin en_b++; head_b = ifb.ccff_head; end
    if (ifb.cfg_valid && ifb.cfg_ready) acc_b++;
    if (ifb.done) begin done_b++; done_cyc_b = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // One full load of chain A; stall counts are LOAD cycles with cfg_valid low before each word.
  task automatic load_a(input logic [7:0] w0, input logic [7:0] w1, input int st0, input int st1,
                        input bit mid_start, output logic [LEN_A-1:0] bits);
    logic [7:0]  words[2];
    logic [15:0] cat;
    logic [LEN_A-1:0] exp_bits;
    int wi, stall_left, stall_en, guard, t0;
    bit mid_req, mid_used;
    words[0] = w0; words[1] = w1;
    cat = {w1, w0};
    got_a.delete(); acc_a.delete(); done_a = 0; head_viol = 0;
    wi = 0; stall_left = st0; stall_en = 0; guard = 0; mid_req = 1'b1; mid_used = 1'b0;
    t0 = cyc;
    while (done_a == 0 && guard < 200) begin
      ifa.start = mid_req;
      mid_req = 1'b0;
      if (wi < 2 && stall_left == 0) begin
        ifa.cfg_valid = 1'b1; ifa.cfg_data = words[wi];
      end else begin
        ifa.cfg_valid = 1'b0; ifa.cfg_data = 8'($urandom);
      end
      @(negedge prog_clk);
      if (ifa.cfg_ready) begin
        if (ifa.cfg_valid) begin
          wi++; stall_left = st1;
        end else if (stall_left > 0) begin
          stall_left--;
          if (ifa.ccff_shift_en) stall_en++;
        end
      end
      if (mid_start && !mid_used && ifa.ccff_shift_en) begin
        mid_req = 1'b1; mid_used = 1'b1;
      end
      step();
      guard++;
    end
    ifa.start = 1'b0; ifa.cfg_valid = 1'b0;
    chk("latency", done_cyc_a - t0 + 1, LEN_A + 2 + 2 + CHK + st0 + st1);
    repeat (4) step();
    bits = '0;
    for (int i = 0; i < LEN_A; i++) begin
      exp_bits[i] = cat[i];
      if (i < got_a.size()) bits[i] = got_a[i];
    end
    chk("done_pulses", done_a, 1);
    chk("enable_cycles", got_a.size(), LEN_A);
    chk("bitstream", 32'(bits), 32'(exp_bits));
    chk("words_accepted", acc_a.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < acc_a.size()) chk("word_value", 32'(acc_a[i]), 32'(words[i]));
    chk("head_zero_idle", head_viol, 0);
    chk("stall_shift_en", stall_en, 0);
    chk("busy_after_done", 32'(ifa.busy), 0);
  endtask

  task automatic reset_mid_a();
    int guard;
    logic [LEN_A-1:0] bits;
    got_a.delete(); done_a = 0; guard = 0;
    ifa.start = 1'b1; step(); ifa.start = 1'b0;
    ifa.cfg_valid = 1'b1; ifa.cfg_data = 8'h5A;
    while (got_a.size() < 5 && guard < 50) begin
      @(negedge prog_clk); #1; guard++;
    end
    @(posedge prog_clk); #2;
    chk("busy_before_reset", 32'(ifa.busy), 1);
    pReset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({ifa.cfg_ready, ifa.ccff_head, ifa.ccff_shift_en,
                                     ifa.busy, ifa.done, ifa.error}), 0);
    @(posedge prog_clk); #1;
    pReset = 1'b0; ifa.cfg_valid = 1'b0;
    repeat (6) step();
    chk("no_done_after_reset", done_a, 0);
    load_a(8'h3C, 8'h09, 0, 0, 1'b0, bits);
  endtask

  task automatic load_b(input logic [7:0] w);
    int t0, guard;
    en_b = 0; acc_b = 0; done_b = 0; guard = 0;
    ifb.start = 1'b1; ifb.cfg_valid = 1'b1; ifb.cfg_data = w; t0 = cyc;
    step();
    ifb.start = 1'b0;
    while (done_b == 0 && guard < 50) begin step(); guard++; end
    ifb.cfg_valid = 1'b0;
    repeat (3) step();
    chk("b_done", done_b, 1);
    chk("b_enable_cycles", en_b, 1);
    chk("b_head", 32'(head_b), 32'(w[0]));
    chk("b_words", acc_b, 1);
    chk("b_latency", done_cyc_b - t0 + 1, LEN_B + 1 + 2 + CHK);
    chk("b_busy_end", 32'(ifb.busy), 0);
  endtask

  initial begin
    logic [LEN_A-1:0] bits_ref, bits_st, bits_x;
    logic [7:0] w0, w1;
    int exp_err;
    ifa.start = 1'b0; ifa.cfg_valid = 1'b0; ifa.cfg_data = '0;
    ifb.start = 1'b0; ifb.cfg_valid = 1'b0; ifb.cfg_data = '0;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("reset_a", 32'({ifa.cfg_ready, ifa.ccff_head, ifa.ccff_shift_en, ifa.busy, ifa.done, ifa.error}), 0);
    chk("reset_b", 32'({ifb.cfg_ready, ifb.ccff_head, ifb.ccff_shift_en, ifb.busy, ifb.done, ifb.error}), 0);
    pReset = 1'b0;
    repeat (2) step();

    load_a(8'hA5, 8'h03, 0, 0, 1'b0, bits_ref);
    chk("a5_03_stream", 32'(bits_ref), 32'h3A5);
    chk("a5_03_error", 32'(ifa.error), 0);
    load_a(8'hA5, 8'h03, 5, 0, 1'b0, bits_st);
    chk("stalled_stream_same", 32'(bits_st), 32'(bits_ref));
    load_a(8'hA5, 8'h03, 0, 2, 1'b1, bits_x);
    reset_mid_a();

    force_tail_en = 1'b1; force_tail_val = 1'b0;
    load_a(8'hA5, 8'h03, 0, 0, 1'b0, bits_x);
    chk("tail_fault_error", 32'(ifa.error), 32'(CHK));
    repeat (5) step();
    chk("tail_fault_held", 32'(ifa.error), 32'(CHK));
    force_tail_val = 1'b1;
    load_a(8'hA5, 8'h03, 0, 0, 1'b0, bits_x);
    chk("tail_ok_error", 32'(ifa.error), 0);
    force_tail_en = 1'b0;

    for (int n = 0; n < 10; n++) begin
      w0 = 8'($urandom); w1 = 8'($urandom);
      force_tail_en  = ($urandom_range(3) == 0);
      force_tail_val = 1'($urandom);
      exp_err = (CHK == 1 && force_tail_en && (force_tail_val != w0[0])) ? 1 : 0;
      load_a(w0, w1, $urandom_range(3), $urandom_range(3), 1'($urandom), bits_x);
      chk("rand_error", 32'(ifa.error), exp_err);
    end
    force_tail_en = 1'b0;

    load_b(8'hFE);
    load_b(8'h01);
    load_b(8'($urandom));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
